axi_r_slice: RTL and testbench

AXI_R_SLICE -- requirements
Module: axi_r_slice

---
 rtl/axi_slice_pkg.sv | 23 ++
 rtl/axi_r_slice_err_cnt.sv | 53 +++++
 rtl/axi_r_slice.sv | 193 +++++++++++++++++++
 tb/tb_axi_r_slice.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_slice_pkg.sv
// axi_slice_pkg -- shared definitions for the AXI channel slices.
// Holds the RRESP encodings, the spill-register state enum and a small
// response-classification helper.
package axi_slice_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // EMPTY: no beat held; HALF: output entry A full; FULL: A and skid B full
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_HALF  = 2'b01,
    ST_FULL  = 2'b10
  } slice_state_e;

  // SLVERR and DECERR both have bit 1 set; OKAY/EXOKAY do not
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp[1];
  endfunction

endpackage

// File: rtl/axi_r_slice_err_cnt.sv
// axi_r_slice_err_cnt -- saturating error-beat counter for axi_r_slice.
// A clear takes priority but a simultaneous error still counts, so the
// result of clear+error is 1. err_o is registered alongside the count.
module axi_r_slice_err_cnt #(
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clr_i,
  input  logic                 inc_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 err_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1'b1);

  logic [CNT_WIDTH-1:0] cnt_r;
  logic [CNT_WIDTH-1:0] cnt_next_s;
  logic                 err_r;

  // Next count: clear (optionally seeded by this cycle's error), else saturating increment
  always_comb begin
    cnt_next_s = cnt_r;
    if (clr_i) begin
      if (inc_i) begin
        cnt_next_s = CNT_ONE;
      end else begin
        cnt_next_s = CNT_ZERO;
      end
    end else if (inc_i && (cnt_r != CNT_MAX)) begin
      cnt_next_s = cnt_r + CNT_ONE;
    end else begin
      cnt_next_s = cnt_r;
    end
  end

  // Count and non-zero flag are registered together so they never disagree
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_r <= CNT_ZERO;
      err_r <= 1'b0;
    end else begin
      cnt_r <= cnt_next_s;
      err_r <= (cnt_next_s != CNT_ZERO);
    end
  end

  assign cnt_o = cnt_r;
  assign err_o = err_r;

endmodule

// File: rtl/axi_r_slice.sv
// axi_r_slice -- AXI read-data channel spill register (two entries).
// Entry A drives master_*; entry B catches the one beat that can arrive
// while downstream stalls, so slave_ready_o comes straight from a flop and
// never depends combinationally on master_ready_i. Full throughput is kept
// while master_ready_i stays high.
// Optional feature: define AXI_R_SLICE_ERR_CNT_EN to count SLVERR/DECERR
// beats handed downstream; otherwise err_cnt_o/err_o are tied low.
module axi_r_slice
  import axi_slice_pkg::*;
#(
  parameter int unsigned ID_WIDTH      = 4,
  parameter int unsigned DATA_WIDTH    = 64,
  parameter int unsigned USER_WIDTH    = 6,
  parameter int unsigned ERR_CNT_WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     slave_valid_i,
  input  logic [DATA_WIDTH-1:0]    slave_data_i,
  input  logic [1:0]               slave_resp_i,
  input  logic [USER_WIDTH-1:0]    slave_user_i,
  input  logic [ID_WIDTH-1:0]      slave_id_i,
  input  logic                     slave_last_i,
  output logic                     slave_ready_o,
  output logic                     master_valid_o,
  output logic [DATA_WIDTH-1:0]    master_data_o,
  output logic [1:0]               master_resp_o,
  output logic [USER_WIDTH-1:0]    master_user_o,
  output logic [ID_WIDTH-1:0]      master_id_o,
  output logic                     master_last_o,
  input  logic                     master_ready_i,
  input  logic                     clr_err_i,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt_o,
  output logic                     err_o
);

  localparam int unsigned PAYLOAD_W = DATA_WIDTH + 2 + USER_WIDTH + ID_WIDTH + 1;

  slice_state_e         state_r;
  logic                 slave_ready_r;
  logic                 master_valid_r;
  logic [PAYLOAD_W-1:0] entry_a_r;
  logic [PAYLOAD_W-1:0] entry_b_r;
  logic [PAYLOAD_W-1:0] slave_payload_s;
  logic                 accept_s;
  logic                 drain_s;
  logic                 load_a_s;
  logic                 a_from_b_s;
  logic                 load_b_s;

  assign slave_payload_s = {slave_data_i, slave_resp_i, slave_user_i, slave_id_i, slave_last_i};
  assign accept_s        = slave_valid_i & slave_ready_r;
  assign drain_s         = master_valid_r & master_ready_i;

  // Entry load enables: where an accepted beat lands and when B refills A
  always_comb begin
    load_a_s   = 1'b0;
    a_from_b_s = 1'b0;
    load_b_s   = 1'b0;
    case (state_r)
      ST_EMPTY: begin
        if (accept_s) begin
          load_a_s = 1'b1;
        end else begin
          load_a_s = 1'b0;
        end
      end
      ST_HALF: begin
        if (accept_s && drain_s) begin
          load_a_s = 1'b1;
        end else if (accept_s) begin
          load_b_s = 1'b1;
        end else begin
          load_b_s = 1'b0;
        end
      end
      ST_FULL: begin
        if (drain_s) begin
          a_from_b_s = 1'b1;
        end else begin
          a_from_b_s = 1'b0;
        end
      end
      default: begin
        load_a_s   = 1'b0;
        a_from_b_s = 1'b0;
        load_b_s   = 1'b0;
      end
    endcase
  end

  // Occupancy FSM with registered ready/valid handshake outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r        <= ST_EMPTY;
      slave_ready_r  <= 1'b1;
      master_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (accept_s) begin
            state_r        <= ST_HALF;
            slave_ready_r  <= 1'b1;
            master_valid_r <= 1'b1;
          end else begin
            state_r        <= ST_EMPTY;
            slave_ready_r  <= 1'b1;
            master_valid_r <= 1'b0;
          end
        end
        ST_HALF: begin
          if (accept_s && !drain_s) begin
            state_r        <= ST_FULL;
            slave_ready_r  <= 1'b0;
            master_valid_r <= 1'b1;
          end else if (drain_s && !accept_s) begin
            state_r        <= ST_EMPTY;
            slave_ready_r  <= 1'b1;
            master_valid_r <= 1'b0;
          end else begin
            state_r        <= ST_HALF;
            slave_ready_r  <= 1'b1;
            master_valid_r <= 1'b1;
          end
        end
        ST_FULL: begin
          if (drain_s) begin
            state_r        <= ST_HALF;
            slave_ready_r  <= 1'b1;
            master_valid_r <= 1'b1;
          end else begin
            state_r        <= ST_FULL;
            slave_ready_r  <= 1'b0;
            master_valid_r <= 1'b1;
          end
        end
        default: begin
          state_r        <= ST_EMPTY;
          slave_ready_r  <= 1'b1;
          master_valid_r <= 1'b0;
        end
      endcase
    end
  end

  // Output entry A: new beat on accept, or the skid beat when B moves forward
  always_ff @(posedge clk_i) begin
    if (load_a_s) begin
      entry_a_r <= slave_payload_s;
    end else if (a_from_b_s) begin
      entry_a_r <= entry_b_r;
    end else begin
      entry_a_r <= entry_a_r;
    end
  end

  // Skid entry B: only captures a beat accepted while A is stalled
  always_ff @(posedge clk_i) begin
    if (load_b_s) begin
      entry_b_r <= slave_payload_s;
    end else begin
      entry_b_r <= entry_b_r;
    end
  end

  assign slave_ready_o  = slave_ready_r;
  assign master_valid_o = master_valid_r;
  assign {master_data_o, master_resp_o, master_user_o, master_id_o, master_last_o} = entry_a_r;

`ifdef AXI_R_SLICE_ERR_CNT_EN
  logic err_inc_s;

  assign err_inc_s = drain_s & resp_is_err(master_resp_o);

  axi_r_slice_err_cnt #(
    .CNT_WIDTH (ERR_CNT_WIDTH)
  ) u_err_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (clr_err_i),
    .inc_i  (err_inc_s),
    .cnt_o  (err_cnt_o),
    .err_o  (err_o)
  );
`else
  logic unused_clr_err_s;

  assign unused_clr_err_s = clr_err_i;
  assign err_cnt_o        = {ERR_CNT_WIDTH{1'b0}};
  assign err_o            = 1'b0;
`endif

endmodule

// File: tb/tb_axi_r_slice.sv
// tb_axi_r_slice -- scoreboard bench for axi_r_slice.
// The driver pushes every accepted beat into an expected queue; an
// independent monitor pops and compares at each downstream handshake, and
// keeps a saturating error-count model (zero unless AXI_R_SLICE_ERR_CNT_EN).
module tb_axi_r_slice;

  localparam int IDW = 4;
  localparam int DW  = 64;
  localparam int UW  = 6;
  localparam int EW  = 8;

  typedef struct packed {
    logic [DW-1:0]  data;
    logic [1:0]     resp;
    logic [UW-1:0]  user;
    logic [IDW-1:0] id;
    logic           last;
  } beat_t;

  logic           clk = 1'b0;
  logic           rst_ni = 1'b0;
  logic           slave_valid_i = 1'b0;
  beat_t          in_beat = '0;
  logic           master_ready_i = 1'b0;
  logic           clr_err_i = 1'b0;
  logic [DW-1:0]  slave_data_i;
  logic [1:0]     slave_resp_i;
  logic [UW-1:0]  slave_user_i;
  logic [IDW-1:0] slave_id_i;
  logic           slave_last_i;
  logic           slave_ready_o;
  logic           master_valid_o;
  logic [DW-1:0]  master_data_o;
  logic [1:0]     master_resp_o;
  logic [UW-1:0]  master_user_o;
  logic [IDW-1:0] master_id_o;
  logic           master_last_o;
  logic [EW-1:0]  err_cnt_o;
  logic           err_o;
  beat_t          out_beat;

  assign slave_data_i = in_beat.data;
  assign slave_resp_i = in_beat.resp;
  assign slave_user_i = in_beat.user;
  assign slave_id_i   = in_beat.id;
  assign slave_last_i = in_beat.last;
  assign out_beat     = {master_data_o, master_resp_o, master_user_o, master_id_o, master_last_o};

  always #5 clk = ~clk;

  axi_r_slice #(
    .ID_WIDTH      (IDW),
    .DATA_WIDTH    (DW),
    .USER_WIDTH    (UW),
    .ERR_CNT_WIDTH (EW)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .slave_valid_i  (slave_valid_i),
    .slave_data_i   (slave_data_i),
    .slave_resp_i   (slave_resp_i),
    .slave_user_i   (slave_user_i),
    .slave_id_i     (slave_id_i),
    .slave_last_i   (slave_last_i),
    .slave_ready_o  (slave_ready_o),
    .master_valid_o (master_valid_o),
    .master_data_o  (master_data_o),
    .master_resp_o  (master_resp_o),
    .master_user_o  (master_user_o),
    .master_id_o    (master_id_o),
    .master_last_o  (master_last_o),
    .master_ready_i (master_ready_i),
    .clr_err_i      (clr_err_i),
    .err_cnt_o      (err_cnt_o),
    .err_o          (err_o)
  );

  beat_t exp_q[$];
  int    pop_cyc_q[$];
  int    n_cmp = 0;
  int    n_fail = 0;
  int    cyc = 0;
  int    exp_err = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic beat_t rand_beat(input logic last);
    beat_t b;
    b.data = {$urandom, $urandom};
    b.resp = 2'($urandom_range(0, 3));
    b.user = UW'($urandom);
    b.id   = IDW'($urandom);
    b.last = last;
    return b;
  endfunction

  function automatic beat_t mk_beat(input logic [DW-1:0] d, input logic [1:0] r, input logic last);
    beat_t b;
    b.data = d;
    b.resp = r;
    b.user = UW'(d);
    b.id   = IDW'(d);
    b.last = last;
    return b;
  endfunction

  // One bus cycle: inputs applied now (just after a rising edge), accept decided at the edge
  task automatic drive_cycle(input logic v, input beat_t b, input logic rdy, input logic clr,
                             output logic acc);
    slave_valid_i  = v;
    in_beat        = b;
    master_ready_i = rdy;
    clr_err_i      = clr;
    @(negedge clk);
    acc = v && slave_ready_o;
    @(posedge clk);
    #1;
    if (acc) exp_q.push_back(b);
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    slave_valid_i = 1'b0;
    master_ready_i = 1'b0;
    clr_err_i = 1'b0;
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_ni = 1'b1;
  endtask

  // Let everything flow out; a stuck slice counts as a failure
  task automatic drain(input string name);
    logic a;
    int   n = 0;
    while ((exp_q.size() != 0 || master_valid_o) && n < 100) begin
      drive_cycle(1'b0, in_beat, 1'b1, 1'b0, a);
      n++;
    end
    chk({name, "_drain_left"}, 128'(exp_q.size()), 128'd0);
  endtask

  // Monitor: handshake scoreboard, stall stability and error-count model
  initial begin
    logic  prev_stall = 1'b0;
    beat_t prev_out = '0;
    beat_t e;
    logic  hs_err;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_ni) begin
        prev_stall = 1'b0;
        exp_err = 0;
      end else begin
        chk("err_cnt", 128'(err_cnt_o), 128'(exp_err));
        chk("err_flag", 128'(err_o), 128'(exp_err != 0));
        if (prev_stall) begin
          chk("stall_valid", 128'(master_valid_o), 128'd1);
          chk("stall_payload", 128'(out_beat), 128'(prev_out));
        end
        hs_err = 1'b0;
        if (master_valid_o && master_ready_i) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL extra_beat: got %0h expected no beat (t=%0t)", out_beat, $time);
          end else begin
            e = exp_q.pop_front();
            chk("beat", 128'(out_beat), 128'(e));
            pop_cyc_q.push_back(cyc);
            hs_err = e.resp[1];
          end
        end
`ifdef AXI_R_SLICE_ERR_CNT_EN
        if (clr_err_i) exp_err = hs_err ? 1 : 0;
        else if (hs_err && exp_err < (2 ** EW) - 1) exp_err = exp_err + 1;
`endif
        prev_stall = master_valid_o && !master_ready_i;
        prev_out   = out_beat;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic  a;
    beat_t b0, b1, b2, cur;
    logic  v, holding;
    int    acc_n, guard;
    logic [1:0] resps [6];

    do_reset();

    // Reset state
    chk("rst_master_valid", 128'(master_valid_o), 128'd0);
    chk("rst_slave_ready", 128'(slave_ready_o), 128'd1);
    chk("rst_err_cnt", 128'(err_cnt_o), 128'd0);
    chk("rst_err", 128'(err_o), 128'd0);

    // Single beat latency
    b0 = mk_beat(64'hA5, 2'b00, 1'b1);
    chk("lat_slave_ready", 128'(slave_ready_o), 128'd1);
    drive_cycle(1'b1, b0, 1'b0, 1'b0, a);
    chk("lat_accept", 128'(a), 128'd1);
    chk("lat_master_valid", 128'(master_valid_o), 128'd1);
    chk("lat_data", 128'(master_data_o), 128'hA5);
    drain("lat");

    // 16-beat burst with downstream always ready
    pop_cyc_q.delete();
    acc_n = 0;
    for (int i = 0; i < 16; i++) begin
      drive_cycle(1'b1, rand_beat(i == 15), 1'b1, 1'b0, a);
      if (a) acc_n++;
    end
    drain("burst");
    chk("burst_accepts", 128'(acc_n), 128'd16);
    chk("burst_pops", 128'(pop_cyc_q.size()), 128'd16);
    if (pop_cyc_q.size() == 16)
      chk("burst_bubbles", 128'(pop_cyc_q[15] - pop_cyc_q[0]), 128'd15);

    // Backpressure: three beats offered, two fit
    b0 = rand_beat(1'b0);
    b1 = rand_beat(1'b0);
    b2 = rand_beat(1'b1);
    drive_cycle(1'b1, b0, 1'b0, 1'b0, a);
    chk("bp_acc0", 128'(a), 128'd1);
    drive_cycle(1'b1, b1, 1'b0, 1'b0, a);
    chk("bp_acc1", 128'(a), 128'd1);
    chk("bp_ready_low", 128'(slave_ready_o), 128'd0);
    drive_cycle(1'b1, b2, 1'b0, 1'b0, a);
    chk("bp_acc2_blocked", 128'(a), 128'd0);
    chk("bp_hold_a", 128'(out_beat), 128'(b0));
    drive_cycle(1'b1, b2, 1'b1, 1'b0, a);
    chk("bp_full_no_accept", 128'(a), 128'd0);
    chk("bp_half_valid", 128'(master_valid_o), 128'd1);
    chk("bp_half_ready", 128'(slave_ready_o), 128'd1);
    chk("bp_b_to_a", 128'(out_beat), 128'(b1));
    drive_cycle(1'b1, b2, 1'b1, 1'b0, a);
    chk("bp_acc2", 128'(a), 128'd1);
    drain("bp");

    // Randomized traffic, 10k beats, occasional counter clears
    acc_n = 0;
    guard = 0;
    holding = 1'b0;
    v = 1'b0;
    cur = '0;
    while (acc_n < 10000 && guard < 40000) begin
      if (!holding) begin
        v = ($urandom_range(0, 3) != 0);
        cur = rand_beat(1'($urandom));
      end
      drive_cycle(v, cur, ($urandom_range(0, 2) != 0), ($urandom_range(0, 63) == 0), a);
      if (a) acc_n++;
      holding = v && !a;
      guard++;
    end
    chk("rand_beats", 128'(acc_n), 128'd10000);
    drain("rand");

    // Reset while FULL: output dies immediately, nothing stale afterwards
    drive_cycle(1'b1, rand_beat(1'b0), 1'b0, 1'b0, a);
    drive_cycle(1'b1, rand_beat(1'b0), 1'b0, 1'b0, a);
    chk("full_before_rst", 128'(slave_ready_o), 128'd0);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("rst_async_valid", 128'(master_valid_o), 128'd0);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b0, in_beat, 1'b1, 1'b0, a);
      chk("post_rst_no_beat", 128'(master_valid_o), 128'd0);
    end

`ifdef AXI_R_SLICE_ERR_CNT_EN
    do_reset();
    resps = '{2'b10, 2'b10, 2'b10, 2'b11, 2'b00, 2'b00};
    for (int i = 0; i < 6; i++) drive_cycle(1'b1, mk_beat(64'(i), resps[i], 1'b0), 1'b1, 1'b0, a);
    drain("err6");
    chk("err_four", 128'(err_cnt_o), 128'd4);
    chk("err_four_flag", 128'(err_o), 128'd1);
    for (int i = 0; i < 300; i++) drive_cycle(1'b1, mk_beat(64'(i), 2'b10, 1'b0), 1'b1, 1'b0, a);
    drain("err300");
    chk("err_saturate", 128'(err_cnt_o), 128'd255);
    drive_cycle(1'b1, mk_beat(64'h77, 2'b11, 1'b1), 1'b0, 1'b0, a);
    drive_cycle(1'b0, in_beat, 1'b1, 1'b1, a);
    chk("err_clr_with_err", 128'(err_cnt_o), 128'd1);
    drive_cycle(1'b0, in_beat, 1'b1, 1'b1, a);
    chk("err_clr", 128'(err_cnt_o), 128'd0);
`else
    for (int i = 0; i < 4; i++) drive_cycle(1'b1, mk_beat(64'(i), 2'b11, 1'b0), 1'b1, 1'b0, a);
    drain("noerr");
    chk("err_tied_cnt", 128'(err_cnt_o), 128'd0);
    chk("err_tied_flag", 128'(err_o), 128'd0);
`endif

    slave_valid_i = 1'b0;
    master_ready_i = 1'b0;
    clr_err_i = 1'b0;
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
